// File: rtl/apb_master.sv
// APB requester: single-beat commands over valid/ready, sequenced
// IDLE -> SETUP -> ACCESS, with back-to-back transfers and a wait timeout.
module apb_master #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               p_clk,
    input  logic               p_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic               p_sel,
    output logic               p_enable,
    output logic               p_write,
    output logic [A_WIDTH-1:0] p_addr,
    output logic [D_WIDTH-1:0] wr_data,
    input  logic [D_WIDTH-1:0] rd_data,
    input  logic               p_ready
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_wait;
    logic               r_write;
    logic [A_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0] r_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [D_WIDTH-1:0] r_rsp_rdata;
    logic               w_ready;
    logic               w_accept;
    logic               w_done;
    logic               w_abort;

    always_comb begin
        w_ready  = !p_rst && ((r_state == S_IDLE) ||
                              (r_state == S_ACCESS && p_ready));
        w_accept = cmd_valid && w_ready;
        w_done   = (r_state == S_ACCESS) && p_ready;
        // Abort fires on the last allowed wait cycle, never on a ready one.
        w_abort  = (TIMEOUT != 0) && (r_state == S_ACCESS) &&
                   !p_ready && (r_wait == LAST);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_done)       w_next = w_accept ? S_SETUP : S_IDLE;
                else if (w_abort) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            r_wait      <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == S_SETUP) begin
                r_wait <= '0;
            end else if (r_state == S_ACCESS && !p_ready &&
                         TIMEOUT != 0 && r_wait != CMAX) begin
                r_wait <= r_wait + 1'b1;
            end
            r_rsp_valid <= w_done || w_abort;
            r_rsp_err   <= w_abort;
            r_rsp_rdata <= (w_done && !r_write) ? rd_data : '0;
        end
    end

    assign cmd_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_state != S_IDLE);
    assign p_sel     = (r_state != S_IDLE);
    assign p_enable  = (r_state == S_ACCESS);
    assign p_write   = r_write;
    assign p_addr    = r_addr;
    assign wr_data   = r_wdata;

endmodule

// File: tb/tb_apb_master.sv
// Table-driven bench for apb_master: one vector per cycle, plus a
// hand-written sequence for the longest wait that still completes.
module tb_apb_master;

    logic       p_clk = 1'b0;
    logic       p_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       p_sel;
    logic       p_enable;
    logic       p_write;
    logic [7:0] p_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       p_ready;

    apb_master #(.A_WIDTH(8), .D_WIDTH(8), .TIMEOUT(4)) dut (
        .p_clk    (p_clk),
        .p_rst    (p_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .p_sel    (p_sel),
        .p_enable (p_enable),
        .p_write  (p_write),
        .p_addr   (p_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .p_ready  (p_ready)
    );

    always #5 p_clk = ~p_clk;

    typedef struct packed {
        logic       rdy;
        logic       sel;
        logic       en;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       rv;
        logic       re;
        logic [7:0] rdata;
        logic       busy;
    } out_t;

    typedef struct {
        logic       rst;
        logic       cv;
        logic       cw;
        logic [7:0] ca;
        logic [7:0] cd;
        logic       pr;
        logic [7:0] rd;
        out_t       exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_rsp = 0;

    always @(negedge p_clk)
        if (rsp_valid === 1'b1) n_rsp++;

    function automatic vec_t mk(
        input logic rst, input logic cv, input logic cw,
        input logic [7:0] ca, input logic [7:0] cd,
        input logic pr, input logic [7:0] rd,
        input logic rdy, input logic sel, input logic en, input logic wr,
        input logic [7:0] addr, input logic [7:0] wd,
        input logic rv, input logic re, input logic [7:0] rdata,
        input logic bsy);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd;
        v.pr = pr; v.rd = rd;
        v.exp = '{rdy, sel, en, wr, addr, wd, rv, re, rdata, bsy};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        out_t act;
        int   lat;
        logic err_seen;

        //         rst cv cw ca     cd     pr rd    | rdy sel en wr addr  wd     rv re rdata  busy
        vq.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        // write 0x45 <- 0xA5, zero wait
        vq.push_back(mk(0, 1, 1, 8'h45, 8'hA5, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 0, 1, 8'h45, 8'hA5, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 1, 1, 1, 8'h45, 8'hA5, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h45, 8'hA5, 1, 0, 8'h00, 0));
        // read 0x65, two wait states
        vq.push_back(mk(0, 1, 0, 8'h65, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h45, 8'hA5, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h65, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h65, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h65, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h12, 1, 1, 1, 0, 8'h65, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h65, 8'h00, 1, 0, 8'h12, 0));
        // back-to-back write 0x55 then read 0x76
        vq.push_back(mk(0, 1, 1, 8'h55, 8'h3C, 0, 8'h00, 1, 0, 0, 0, 8'h65, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 1, 0, 8'h76, 8'h00, 0, 8'h00, 0, 1, 0, 1, 8'h55, 8'h3C, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 1, 0, 8'h76, 8'h00, 1, 8'h00, 1, 1, 1, 1, 8'h55, 8'h3C, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 0, 0, 8'h76, 8'h00, 1, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h9C, 1, 1, 1, 0, 8'h76, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h76, 8'h00, 1, 0, 8'h9C, 0));
        // read 0x30, slave never ready: four ACCESS cycles then abort
        vq.push_back(mk(0, 1, 0, 8'h30, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h76, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h30, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 1, 1, 8'h99, 8'h11, 0, 8'h00, 0, 1, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h30, 8'h00, 1, 1, 8'h00, 0));
        vq.push_back(mk(0, 1, 1, 8'h31, 8'h77, 0, 8'h00, 1, 0, 0, 0, 8'h30, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 1, 0, 1, 8'h31, 8'h77, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 1, 1, 1, 8'h31, 8'h77, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h31, 8'h77, 1, 0, 8'h00, 0));
        // read 0x40, reset during ACCESS
        vq.push_back(mk(0, 1, 0, 8'h40, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h31, 8'h77, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h40, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 8'h55, 0, 1, 1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        // read 0x22, stray command during SETUP is ignored
        vq.push_back(mk(0, 1, 0, 8'h22, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 1, 1, 8'h88, 8'hEE, 0, 8'h00, 0, 1, 0, 0, 8'h22, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 1, 1, 1, 0, 8'h22, 8'h00, 0, 0, 8'h00, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h22, 8'h00, 1, 0, 8'h5A, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h22, 8'h00, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h22, 8'h00, 0, 0, 8'h00, 0));

        p_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 8'h00; cmd_wdata = 8'h00;
        p_ready = 1'b0; rd_data = 8'h00;
        @(negedge p_clk);
        @(negedge p_clk);

        foreach (vq[i]) begin
            @(negedge p_clk);
            p_rst     = vq[i].rst;
            cmd_valid = vq[i].cv;
            cmd_write = vq[i].cw;
            cmd_addr  = vq[i].ca;
            cmd_wdata = vq[i].cd;
            p_ready   = vq[i].pr;
            rd_data   = vq[i].rd;
            #1;
            act = '{cmd_ready, p_sel, p_enable, p_write, p_addr, wr_data,
                    rsp_valid, rsp_err, rsp_rdata, busy};
            n_vec++;
            if (act !== vq[i].exp) begin
                n_bad++;
                $display("FAIL vec%0d: got %h want %h (rdy sel en wr addr wd rv re rdata busy)",
                         i, act, vq[i].exp);
            end
        end

        // Write with three wait states: completes on the cycle the
        // counter reaches its abort value, so no error is raised.
        @(negedge p_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 8'hA0; cmd_wdata = 8'h3F; p_ready = 1'b0;
        #1 chk("hs_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge p_clk);
        cmd_valid = 1'b0;
        #1 chk("hs_setup", {22'd0, p_sel, p_enable, p_addr}, {22'd0, 2'b10, 8'hA0});
        for (int k = 0; k < 3; k++) begin
            @(negedge p_clk);
            p_ready = 1'b0;
            #1 chk("hs_wait", {30'd0, p_sel, p_enable}, 32'd3);
        end
        @(negedge p_clk);
        p_ready = 1'b1;
        #1 chk("hs_last", {30'd0, cmd_ready, p_enable}, 32'd3);
        lat = -1;
        err_seen = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge p_clk);
            p_ready = 1'b0;
            #1;
            if (rsp_valid === 1'b1) begin
                lat = k;
                err_seen = rsp_err;
                break;
            end
        end
        chk("hs_latency", lat, 32'd1);
        chk("hs_err", {31'd0, err_seen}, 32'd0);

        @(negedge p_clk);
        chk("rsp_count", n_rsp, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that drives the APB slave in this subsystem.
- Takes single-beat read/write commands over a valid/ready command port and sequences them through IDLE -> SETUP -> ACCESS.
- Returns read data, or a timeout error, on a one-cycle response strobe.
- Supports back-to-back transfers (ACCESS -> SETUP without returning to IDLE) and a programmable wait-state timeout.

Parameters:
- A_WIDTH, 8, address width.
- D_WIDTH, 8, data width.
- TIMEOUT, 16, maximum ACCESS cycles with p_ready low before abort. 0 disables the timeout.

Ports:
- p_clk  in  1  clock, rising edge.
- p_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a p_clk edge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  A_WIDTH  transfer address.
- cmd_wdata  in  D_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  D_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort.
- busy  out  1  state != IDLE.
- p_sel  out  1  APB select.
- p_enable  out  1  APB enable.
- p_write  out  1  APB direction.
- p_addr  out  A_WIDTH  APB address.
- wr_data  out  D_WIDTH  APB write data.
- rd_data  in  D_WIDTH  APB read data from slave.
- p_ready  in  1  APB ready from slave.

Behaviour:
- Single clock p_clk; reset p_rst is synchronous and active-high.
- Reset values: state=IDLE; p_sel, p_enable, p_write, rsp_valid, rsp_err = 0; p_addr, wr_data, rsp_rdata, wait counter = 0. cmd_ready=0 while p_rst=1.
- States:
  - IDLE (p_sel=0, p_enable=0).
  - SETUP (p_sel=1, p_enable=0).
  - ACCESS (p_sel=1, p_enable=1).
- cmd_ready is combinational: (state==IDLE) || (state==ACCESS && p_ready). It never depends on cmd_valid.
- Accept at edge N: latch cmd_write, cmd_addr, cmd_wdata into p_write, p_addr, wr_data. State=SETUP in cycle N+1.
- p_write, p_addr and wr_data are held stable from SETUP through the final ACCESS cycle. They change only on a new accept.
- SETUP -> ACCESS unconditionally after one cycle. Wait counter cleared on entry to ACCESS.
- ACCESS with p_ready=1 at an edge completes the transfer. In the next cycle:
  - rsp_valid=1, rsp_err=0.
  - rsp_rdata = rd_data sampled at that edge for reads, 0 for writes.
- On completion, if cmd_valid=1 the new command is accepted in the same edge and the next state is SETUP: p_sel stays 1, p_enable drops to 0. Otherwise the next state is IDLE.
- ACCESS with p_ready=0: counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1, abort:
  - next state IDLE;
  - rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle;
  - no command is accepted on that edge.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps; with TIMEOUT=0 it holds at 0.
- Zero-wait latency: accept at edge N -> rsp_valid in cycle N+3. Each wait state adds 1 cycle.
- rsp_valid is exactly one cycle per transfer. There is no response backpressure; the consumer must take it.
- cmd_valid while not ready: the command is ignored. Inputs need not be held, but the command is only accepted on a cmd_ready cycle.
- p_ready/rd_data are ignored outside ACCESS.
- Reset mid-transfer (SETUP or ACCESS): next cycle all outputs return to reset values, no rsp_valid is issued, and the in-flight command is discarded.
- p_enable is never 1 unless p_sel is 1. p_sel/p_enable are never 1/1 for two transfers without an intervening SETUP cycle.

Test Plan:
- Write, zero wait: accept cmd_write=1, addr=0x45, wdata=0xA5 at edge N; slave p_ready=1 -> p_sel=1/p_enable=0 in N+1, 1/1 in N+2, p_addr=0x45, wr_data=0xA5; rsp_valid=1, rsp_err=0, rsp_rdata=0 in N+3; busy=0 in N+3.
- Read, 2 wait states: addr=0x65, slave holds p_ready=0 for 2 ACCESS cycles then 1 with rd_data=0x12 -> ACCESS lasts 3 cycles, p_addr stable; rsp_valid in N+5 with rsp_rdata=0x12, rsp_err=0.
- Back-to-back: write 0x55 then read 0x76, second cmd_valid held high -> cmd_ready=1 in completing ACCESS cycle; next cycle SETUP with p_sel=1, p_enable=0, p_addr=0x76; p_sel never drops between transfers.
- Timeout: TIMEOUT=4, read 0x30, p_ready tied 0 -> exactly 4 ACCESS cycles, then IDLE; rsp_valid=1, rsp_err=1, rsp_rdata=0; next command accepted normally.
- Reset mid-ACCESS: assert p_rst for 1 cycle during a waited read -> next cycle p_sel=0, p_enable=0, p_addr=0, no rsp_valid; cmd_ready=1 the cycle after reset releases.
- Ignored command: cmd_valid pulsed during SETUP only -> not accepted, no extra transfer, rsp_valid count equals accepted commands.
